// File: rtl/laser_link_bist_if.sv
`default_nettype none
// ============================================================================
//  Module      : laser_link_bist_if
//  Description : Port bundle for the laser link BIST. The master side drives
//                start / looped-back lanes; the slave side is the BIST engine.
//                With LASER_BIST_LANE_MASK_EN defined a lane_mask is added.
//  Revision    : 1.0 - initial release
// ============================================================================
interface laser_link_bist_if #(
  parameter int LANES   = 4,
  parameter int LAT_MAX = 15
);
  localparam int LAT_W = $clog2(LAT_MAX + 1);

  logic             start;
  logic [LANES-1:0] rx_lanes;
  logic [LANES-1:0] tx_lanes;
  logic             busy;
  logic             done;
  logic             pass;
  logic             timeout;
  logic [15:0]      err_count;
  logic [LAT_W-1:0] latency;
`ifdef LASER_BIST_LANE_MASK_EN
  logic [LANES-1:0] lane_mask;

  modport master (
    output start, rx_lanes, lane_mask,
    input  tx_lanes, busy, done, pass, timeout, err_count, latency
  );

  modport slave (
    input  start, rx_lanes, lane_mask,
    output tx_lanes, busy, done, pass, timeout, err_count, latency
  );
`else
  modport master (
    output start, rx_lanes,
    input  tx_lanes, busy, done, pass, timeout, err_count, latency
  );

  modport slave (
    input  start, rx_lanes,
    output tx_lanes, busy, done, pass, timeout, err_count, latency
  );
`endif
endinterface
`default_nettype wire

// File: rtl/laser_link_bist.sv
`default_nettype none
// ============================================================================
//  Module      : laser_link_bist
//  Description : Built-in self-test for the multi-lane laser GPIO link. Sends
//                a marker to measure loopback latency, then an LFSR frame, and
//                counts bit errors on the returned lanes.
//                Optional feature macro: LASER_BIST_LANE_MASK_EN (per-lane mask).
//                LANES must be 1..16; interface parameters must match.
//  Revision    : 1.0 - initial release
// ============================================================================
module laser_link_bist #(
  parameter int          LANES     = 4,
  parameter int          FRAME_LEN = 64,
  parameter int          LAT_MAX   = 15,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  laser_link_bist_if.slave        bus
);
  localparam int LAT_W = $clog2(LAT_MAX + 1);
  localparam int CNT_W = $clog2(FRAME_LEN + LAT_MAX + 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_align = 2'd1;
  localparam logic [1:0] c_st_run   = 2'd2;
  localparam logic [1:0] c_st_done  = 2'd3;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_lfsr;
  logic [LANES-1:0] r_rx;
  logic [LANES-1:0] r_hist [LAT_MAX];
  logic [LAT_W-1:0] r_lat;
  logic [15:0]      r_err;
  logic             r_pass;
  logic             r_timeout;

  logic [LANES-1:0] w_mask;
  logic             w_mask_zero;
  logic [LANES-1:0] w_tx_raw;
  logic [LANES-1:0] w_tx;
  logic [LANES-1:0] w_exp;
  logic [LANES-1:0] w_diff;
  logic [LAT_W-1:0] w_idx;
  logic [CNT_W-1:0] w_lat_ext;
  logic [4:0]       w_pop;
  logic [16:0]      w_sum;
  logic [15:0]      w_err_next;
  logic             w_marker;
  logic             w_cmp;
  logic             w_run_last;
  logic             w_start_ok;
  logic             w_lfsr_fb;

`ifdef LASER_BIST_LANE_MASK_EN
  logic [LANES-1:0] r_mask;

  // Lane mask is captured at start and held for the whole test
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '1;
    end else if (w_start_ok) begin
      r_mask <= bus.lane_mask;
    end
  end

  assign w_mask      = r_mask;
  assign w_mask_zero = (bus.lane_mask == '0);
`else
  assign w_mask      = '1;
  assign w_mask_zero = 1'b0;
`endif

  assign w_start_ok = bus.start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lat_ext  = CNT_W'(r_lat);
  assign w_run_last = (r_cnt == w_lat_ext + CNT_W'(FRAME_LEN - 1));

  // Transmit word, expected word and saturating error accumulation
  always_comb begin
    w_tx_raw = '0;
    if ((r_state == c_st_align) && (r_cnt == '0)) begin
      w_tx_raw = '1;
    end else if ((r_state == c_st_run) && (r_cnt < CNT_W'(FRAME_LEN))) begin
      w_tx_raw = r_lfsr[LANES-1:0];
    end
    w_tx     = w_tx_raw & w_mask;
    // Masked-off lanes count as "marker seen" so only live lanes gate alignment
    w_marker = &(r_rx | ~w_mask);
    w_idx    = (r_lat == '0) ? '0 : r_lat - 1'b1;
    w_exp    = r_hist[w_idx];
    w_cmp    = (r_state == c_st_run) && (r_cnt >= w_lat_ext);
    w_diff   = (r_rx ^ w_exp) & w_mask;
    w_pop    = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pop = w_pop + 5'(w_diff[i]);
    end
    w_sum      = {1'b0, r_err} + 17'(w_pop);
    w_err_next = r_err;
    if (w_cmp) begin
      w_err_next = w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end
  end

  // Rx sample register and tx history line used as the expected-data source
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx <= '0;
      for (int i = 0; i < LAT_MAX; i++) begin
        r_hist[i] <= '0;
      end
    end else begin
      r_rx      <= bus.rx_lanes;
      r_hist[0] <= w_tx;
      for (int i = 1; i < LAT_MAX; i++) begin
        r_hist[i] <= r_hist[i-1];
      end
    end
  end

  // Test sequencer: IDLE -> ALIGN -> RUN -> DONE, result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_cnt     <= '0;
      r_lfsr    <= SEED;
      r_lat     <= '0;
      r_err     <= '0;
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (w_start_ok) begin
            r_cnt     <= '0;
            r_lfsr    <= SEED;
            r_lat     <= '0;
            r_err     <= '0;
            r_pass    <= 1'b0;
            r_timeout <= w_mask_zero;
            r_state   <= w_mask_zero ? c_st_done : c_st_align;
          end else begin
            r_state <= c_st_idle;
          end
        end
        c_st_align: begin
          // Marker launched at count 0 can only return from count 1 onward
          if ((r_cnt != '0) && w_marker) begin
            r_lat   <= r_cnt[LAT_W-1:0];
            r_cnt   <= '0;
            r_state <= c_st_run;
          end else if (r_cnt == CNT_W'(LAT_MAX)) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_state   <= c_st_done;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_st_run: begin
          if (r_cnt < CNT_W'(FRAME_LEN)) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
          end
          r_err <= w_err_next;
          if (w_run_last) begin
            r_pass  <= (w_err_next == 16'h0000) && !r_timeout;
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.tx_lanes  = w_tx;
  assign bus.busy      = (r_state == c_st_align) || (r_state == c_st_run);
  assign bus.done      = (r_state == c_st_done);
  assign bus.pass      = r_pass;
  assign bus.timeout   = r_timeout;
  assign bus.err_count = r_err;
  assign bus.latency   = r_lat;

endmodule
`default_nettype wire

// File: tb/tb_laser_link_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_laser_link_bist
//  Description : Scoreboard bench for laser_link_bist. Stimulus pushes the
//                expected result of each test; a monitor pops and compares on
//                every done pulse. Lane-mask tests run when
//                LASER_BIST_LANE_MASK_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_laser_link_bist;
  localparam int          LANES     = 4;
  localparam int          FRAME_LEN = 64;
  localparam int          LAT_MAX   = 15;
  localparam logic [15:0] SEED      = 16'hACE1;

  typedef struct {
    string nm;
    int    lat;
    int    pass;
    int    tmo;
    int    err;
    int    dly;
    int    t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         cyc = 0;
  int         mode = 0;
  logic       stuck_en = 1'b0;
  logic [3:0] dl [4];
  int         n_cmp = 0;
  int         n_fail = 0;
  exp_t       q[$];
  exp_t       mon_e;

  laser_link_bist_if #(.LANES(LANES), .LAT_MAX(LAT_MAX)) bus ();

  laser_link_bist #(
    .LANES(LANES), .FRAME_LEN(FRAME_LEN), .LAT_MAX(LAT_MAX), .SEED(SEED)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time done pulses
  always @(posedge clk) cyc <= cyc + 1;

  // External 4-register loop; with the BIST's rx sample it forms a 5-cycle loop
  always_ff @(posedge clk) begin
    dl[0] <= bus.tx_lanes;
    dl[1] <= dl[0];
    dl[2] <= dl[1];
    dl[3] <= dl[2];
  end

  // Loopback channel models
  always_comb begin
    case (mode)
      0:       bus.rx_lanes = bus.tx_lanes;
      1:       bus.rx_lanes = dl[3];
      2:       bus.rx_lanes = bus.tx_lanes & (stuck_en ? 4'b1011 : 4'b1111);
      4:       bus.rx_lanes = bus.tx_lanes & 4'b1011;
      default: bus.rx_lanes = '0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Number of ones the LFSR frame puts on one lane
  function automatic int lane_ones(input int lane);
    logic [15:0] l;
    int          n;
    l = SEED;
    n = 0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      n += int'(l[lane]);
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
    return n;
  endfunction

  // Cycles from the start-accept edge to the done pulse for loop latency L
  function automatic int exp_dly(input int lat);
    return (lat + 1) + (lat + FRAME_LEN);
  endfunction

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.nm, "_latency"},    int'(bus.latency),   mon_e.lat);
        chk({mon_e.nm, "_pass"},       int'(bus.pass),      mon_e.pass);
        chk({mon_e.nm, "_timeout"},    int'(bus.timeout),   mon_e.tmo);
        chk({mon_e.nm, "_err_count"},  int'(bus.err_count), mon_e.err);
        chk({mon_e.nm, "_done_cycle"}, cyc - mon_e.t0,      mon_e.dly);
      end
    end
  end

  // Called at a negedge: record expectation and pulse start for one cycle
  task automatic start_test(input string nm, input int lat, input int pass_,
                            input int tmo, input int err, input int dly);
    exp_t e;
    e = '{nm: nm, lat: lat, pass: pass_, tmo: tmo, err: err, dly: dly, t0: cyc + 1};
    q.push_back(e);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) chk({nm, "_done_wait"}, 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_tx"},        int'(bus.tx_lanes),  0);
    chk({nm, "_busy"},      int'(bus.busy),      0);
    chk({nm, "_done"},      int'(bus.done),      0);
    chk({nm, "_pass"},      int'(bus.pass),      0);
    chk({nm, "_timeout"},   int'(bus.timeout),   0);
    chk({nm, "_err_count"}, int'(bus.err_count), 0);
    chk({nm, "_latency"},   int'(bus.latency),   0);
  endtask

  initial begin
    exp_t dummy;
    bus.start = 1'b0;
`ifdef LASER_BIST_LANE_MASK_EN
    bus.lane_mask = 4'hF;
`endif
    idle(3);
    check_reset_state("reset");
    rst = 1'b0;
    idle(2);

    // Direct wire loop
    mode = 0;
    start_test("direct", 1, 1, 0, 0, exp_dly(1));
    wait_done("direct", 300);
    idle(8);

    // Five-cycle loop
    mode = 1;
    start_test("delay5", 5, 1, 0, 0, exp_dly(5));
    wait_done("delay5", 300);
    idle(8);

    // Lane 2 stuck low once the marker has returned
    mode = 2;
    start_test("stuck2", 1, 0, 0, lane_ones(2), exp_dly(1));
    @(negedge clk);
    stuck_en = 1'b1;
    wait_done("stuck2", 300);
    stuck_en = 1'b0;
    idle(8);

    // Dead link: marker never returns
    mode = 3;
    start_test("timeout", 0, 0, 1, 0, LAT_MAX + 1);
    wait_done("timeout", 300);
    idle(8);

    // Reset asserted mid-RUN aborts without done
    mode = 0;
    start_test("abort", 1, 1, 0, 0, exp_dly(1));
    idle(20);
    rst = 1'b1;
    dummy = q.pop_back();
    @(negedge clk);
    check_reset_state("midreset");
    rst = 1'b0;
    idle(100);
    start_test("after_reset", 1, 1, 0, 0, exp_dly(1));
    wait_done("after_reset", 300);
    idle(8);

    // Start during RUN is ignored; start on the done cycle restarts
    start_test("ignore_start", 1, 1, 0, 0, exp_dly(1));
    idle(20);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("ignore_start", 300);
    start_test("restart", 1, 1, 0, 0, exp_dly(1));
    wait_done("restart", 300);
    idle(8);

`ifdef LASER_BIST_LANE_MASK_EN
    // Lane 2 stuck for the whole test but masked off
    mode = 4;
    bus.lane_mask = 4'b1011;
    start_test("mask_1011", 1, 1, 0, 0, exp_dly(1));
    wait_done("mask_1011", 300);
    idle(8);
    // All lanes masked: immediate DONE with timeout
    bus.lane_mask = 4'b0000;
    start_test("mask_zero", 0, 0, 1, 0, 0);
    idle(8);
    bus.lane_mask = 4'hF;
`endif

    if (q.size() != 0) chk("pending_expectations", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
